// File: rtl/fsm_run_generator.sv
// Serial run-length transmitter: {bit, len} commands become len cycles of bit on tx_bit_o.
// Optional one-cycle inverted gap after each run when FSM_RUN_GAP_EN is defined.
module fsm_run_generator #(
   parameter int   LEN_W    = 4,
   parameter logic IDLE_VAL = 1'b0
) (
   input  logic             clock_i,
   input  logic             reset_n_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic             cmd_bit_i,
   input  logic [LEN_W-1:0] cmd_len_i,
   output logic             tx_bit_o,
   output logic             tx_active_o,
   output logic             run_done_o
);

`ifdef FSM_RUN_GAP_EN
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SEND} state_t;
`endif

   localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             bit_q, bit_d;
   logic             tx_bit_q, tx_bit_d;
   logic             tx_active_q, tx_active_d;
   logic             run_done_q, run_done_d;
   logic             last_bit;
   logic             accept;
   logic             load;

   assign last_bit = (state_q == S_SEND) && (cnt_q == CNT_ONE);

   // Ready depends only on state and count so it never combinationally follows cmd_valid_i.
   always_comb begin
      cmd_ready_o = 1'b0;
      case (state_q)
         S_IDLE:  cmd_ready_o = 1'b1;
`ifdef FSM_RUN_GAP_EN
         S_GAP:   cmd_ready_o = 1'b1;
         S_SEND:  cmd_ready_o = 1'b0;
`else
         S_SEND:  cmd_ready_o = last_bit;
`endif
         default: cmd_ready_o = 1'b0;
      endcase
   end

   assign accept = cmd_valid_i & cmd_ready_o;
   assign load   = accept && (cmd_len_i != '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               state_d = S_SEND;
               cnt_d   = cmd_len_i;
               bit_d   = cmd_bit_i;
            end
         end
         S_SEND: begin
            if (cnt_q > CNT_ONE) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
`ifdef FSM_RUN_GAP_EN
               state_d = S_GAP;
               cnt_d   = '0;
`else
               // A zero-length command accepted here is dropped and the run ends normally.
               if (load) begin
                  cnt_d = cmd_len_i;
                  bit_d = cmd_bit_i;
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
`endif
            end
         end
`ifdef FSM_RUN_GAP_EN
         S_GAP: begin
            if (load) begin
               state_d = S_SEND;
               cnt_d   = cmd_len_i;
               bit_d   = cmd_bit_i;
            end else begin
               state_d = S_IDLE;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are precomputed from the next state so they are registered yet align with the state.
   always_comb begin
      tx_active_d = (state_d == S_SEND);
      run_done_d  = (state_d == S_SEND) && (cnt_d == CNT_ONE);
      tx_bit_d    = IDLE_VAL;
      if (state_d == S_SEND) begin
         tx_bit_d = bit_d;
      end
`ifdef FSM_RUN_GAP_EN
      else if (state_d == S_GAP) begin
         tx_bit_d = ~bit_q;
      end
`endif
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= 1'b0;
         tx_bit_q    <= IDLE_VAL;
         tx_active_q <= 1'b0;
         run_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         tx_bit_q    <= tx_bit_d;
         tx_active_q <= tx_active_d;
         run_done_q  <= run_done_d;
      end
   end

   assign tx_bit_o    = tx_bit_q;
   assign tx_active_o = tx_active_q;
   assign run_done_o  = run_done_q;

endmodule
